// File: rtl/product_divider.sv
// product_divider: 32/16 unsigned restoring divider, one quotient bit per clock.
module product_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic [31:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_q;
  logic [15:0] r_rem, r_div, w_diff;
  logic [4:0]  r_cnt;
  logic        r_dbz, w_accept, w_zero, w_ge;
  logic [16:0] w_sh;
  always_comb begin
    w_accept = start && r_state != DIV;
    w_zero   = divisor == 16'd0;
    w_next   = w_accept ? (w_zero ? DONE : DIV) :
               r_state == DIV ? (r_cnt == 5'd31 ? DONE : DIV) : IDLE;
    w_sh     = {r_rem, r_q[31]};
    w_ge     = w_sh >= {1'b0, r_div};
    w_diff   = w_sh[15:0] - r_div;
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // A zero divisor skips iteration and returns the saturated quotient directly.
  always_ff @(posedge clk)
    if (rst) begin
      r_q   <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dbz <= w_zero;
      r_div <= divisor;
      r_cnt <= '0;
      r_q   <= w_zero ? 32'hFFFF_FFFF : dividend;
      r_rem <= w_zero ? dividend[15:0] : 16'd0;
    end else if (r_state == DIV) begin
      r_q   <= {r_q[30:0], w_ge};
      r_rem <= w_ge ? w_diff : w_sh[15:0];
      r_cnt <= r_cnt + 5'd1;
    end
  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign busy        = r_state == DIV;
  assign done        = r_state == DONE;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_product_divider.sv
// tb_product_divider: directed and randomised checks of product_divider.
module tb_product_divider;
  logic        clk = 0, rst = 0, start = 0;
  logic [31:0] dividend = 0;
  logic [15:0] divisor = 0;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        busy, done, div_by_zero;
  int          tests = 0, fails = 0;

  product_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [15:0] b, output int lat,
                       output logic busy_seen, output logic overlap, output logic busy_first);
    dividend = a; divisor = b; start = 1;
    tick(1);
    start = 0;
    lat = 1; busy_first = busy; busy_seen = busy; overlap = busy && done;
    while (!done && lat < 100) begin
      tick(1);
      lat++;
      busy_seen |= busy; overlap |= busy && done;
    end
  endtask

  task automatic test_reset;
    rst = 1; start = 1; dividend = 32'h1234; divisor = 16'h3;
    tick(3);
    rst = 0; start = 0;
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 51'd0) begin
      fails++;
      $display("FAIL reset: q=%h r=%h busy=%b done=%b dbz=%b, want all 0", quotient, remainder, busy, done, div_by_zero);
    end
    tick(1);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors;
    logic [31:0] va [4] = '{32'h0000FFFE, 32'hFFFE0001, 32'hAB213305, 32'hFFFFFFFF};
    logic [15:0] vb [4] = '{16'h0002, 16'hFFFF, 16'hFF00, 16'h0001};
    logic [31:0] vq [4] = '{32'h00007FFF, 32'h0000FFFF, 32'h0000ABCD, 32'hFFFFFFFF};
    logic [15:0] vr [4] = '{16'h0000, 16'h0000, 16'h0005, 16'h0000};
    int lat; logic bs, ov, bf;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], lat, bs, ov, bf);
      tests++;
      if (lat !== 33 || quotient !== vq[i] || remainder !== vr[i] || div_by_zero !== 1'b0 || ov !== 1'b0 || bf !== 1'b1) begin
        fails++;
        $display("FAIL vec%0d: lat=%0d q=%h r=%h dbz=%b ov=%b busy0=%b, want lat=33 q=%h r=%h dbz=0 ov=0 busy0=1",
                 i, lat, quotient, remainder, div_by_zero, ov, bf, vq[i], vr[i]);
      end
      tick(1);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || quotient !== vq[i] || remainder !== vr[i]) begin
        fails++;
        $display("FAIL vec%0d_hold: done=%b busy=%b q=%h r=%h, want done=0 busy=0 q=%h r=%h", i, done, busy, quotient, remainder, vq[i], vr[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat; logic bs, ov, bf;
    do_op(32'h12345678, 16'h0000, lat, bs, ov, bf);
    tests++;
    if (lat !== 1 || quotient !== 32'hFFFFFFFF || remainder !== 16'h5678 || div_by_zero !== 1'b1 || bs !== 1'b0) begin
      fails++;
      $display("FAIL div0: lat=%0d q=%h r=%h dbz=%b busy_seen=%b, want lat=1 q=ffffffff r=5678 dbz=1 busy_seen=0",
               lat, quotient, remainder, div_by_zero, bs);
    end
    tick(2);
    tests++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL div0_hold: dbz=%b done=%b, want 1 0", div_by_zero, done);
    end
    do_op(32'h00000064, 16'h000A, lat, bs, ov, bf);
    tests++;
    if (div_by_zero !== 1'b0 || quotient !== 32'd10 || remainder !== 16'd0) begin
      fails++; $display("FAIL div0_clear: dbz=%b q=%h r=%h, want 0 0000000a 0000", div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic bs, ov, bf;
    dividend = 32'hAB213305; divisor = 16'hFF00; start = 1;
    tick(1);
    start = 0; lat = 1;
    tick(9); lat += 9;
    dividend = 32'h00000010; divisor = 16'h0003; start = 1;
    tick(1); lat++;
    start = 0; dividend = 32'h0; divisor = 16'h0;
    while (!done && lat < 100) begin tick(1); lat++; end
    tests++;
    if (lat !== 33 || quotient !== 32'h0000ABCD || remainder !== 16'h0005) begin
      fails++; $display("FAIL ignore_start: lat=%0d q=%h r=%h, want lat=33 q=0000abcd r=0005", lat, quotient, remainder);
    end
    do_op(32'h00001000, 16'h0007, lat, bs, ov, bf);
    tests++;
    if (bf !== 1'b1 || lat !== 33 || quotient !== 32'h00000249 || remainder !== 16'h0001) begin
      fails++; $display("FAIL back_to_back: busy0=%b lat=%0d q=%h r=%h, want busy0=1 lat=33 q=00000249 r=0001", bf, lat, quotient, remainder);
    end
    do_op(32'h00000009, 16'h0000, lat, bs, ov, bf);
    tests++;
    if (lat !== 1 || bf !== 1'b0 || div_by_zero !== 1'b1 || remainder !== 16'h0009) begin
      fails++; $display("FAIL b2b_div0: lat=%0d busy0=%b dbz=%b r=%h, want lat=1 busy0=0 dbz=1 r=0009", lat, bf, div_by_zero, remainder);
    end
    tick(1);
  endtask

  task automatic test_reset_mid;
    int lat; logic bs, ov, bf, seen_done;
    dividend = 32'hFFFFFFFF; divisor = 16'h0003; start = 1;
    tick(1);
    start = 0;
    tick(15);
    rst = 1;
    tick(1);
    rst = 0;
    tests++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 51'd0) begin
      fails++;
      $display("FAIL reset_mid: q=%h r=%h busy=%b done=%b dbz=%b, want all 0", quotient, remainder, busy, done, div_by_zero);
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin tick(1); seen_done |= done | busy; end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++; $display("FAIL reset_abort: done_or_busy_seen=%b, want 0", seen_done);
    end
    do_op(32'hFFFFFFFF, 16'h0003, lat, bs, ov, bf);
    tests++;
    if (lat !== 33 || quotient !== 32'h55555555 || remainder !== 16'h0000) begin
      fails++; $display("FAIL reset_resume: lat=%0d q=%h r=%h, want lat=33 q=55555555 r=0000", lat, quotient, remainder);
    end
    tick(1);
    rst = 1; start = 1; dividend = 32'h5; divisor = 16'h0;
    tick(1);
    rst = 0; start = 0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      fails++; $display("FAIL reset_priority: busy=%b done=%b dbz=%b, want 0 0 0", busy, done, div_by_zero);
    end
  endtask

  task automatic test_random;
    int lat; logic bs, ov, bf;
    logic [15:0] a, b, d;
    logic [31:0] n;
    logic [63:0] recon;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(1, 65535)); b = 16'($urandom);
      do_op(32'(a) * 32'(b), a, lat, bs, ov, bf);
      tests++;
      if (lat !== 33 || quotient !== 32'(b) || remainder !== 16'd0) begin
        fails++; $display("FAIL rand_mul%0d: a=%h b=%h lat=%0d q=%h r=%h, want q=%h r=0", i, a, b, lat, quotient, remainder, b);
      end
    end
    for (int i = 0; i < 200; i++) begin
      n = $urandom; d = 16'($urandom_range(1, 65535));
      if (i % 4 == 0) d = 16'($urandom_range(1, 15));
      do_op(n, d, lat, bs, ov, bf);
      recon = 64'(quotient) * 64'(d) + 64'(remainder);
      tests++;
      if (recon !== 64'(n) || remainder >= d || lat !== 33) begin
        fails++; $display("FAIL rand_div%0d: n=%h d=%h q=%h r=%h lat=%0d, want q*d+r=n r<d lat=33", i, n, d, quotient, remainder, lat);
      end
    end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_vectors;
    test_div_by_zero;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/product_divider.md
PRODUCT_DIVIDER -- requirements
Module: product_divider

Interface
- REQ-001: No parameters; all widths fixed (32-bit dividend, 16-bit divisor), the inverse of the team's 16x16->32 multiplier.
- REQ-002: clk  input  1  rising-edge clock; sole clock of the block.
- REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising clk.
- REQ-004: start  input  1  request to begin a division; sampled on rising clk.
- REQ-005: dividend  input  32  unsigned dividend; sampled only on an accepted start.
- REQ-006: divisor  input  16  unsigned divisor; sampled only on an accepted start.
- REQ-007: quotient  output  32  unsigned quotient of the last completed division.
- REQ-008: remainder  output  16  unsigned remainder of the last completed division.
- REQ-009: busy  output  1  high while an iteration is in progress.
- REQ-010: done  output  1  one-cycle pulse marking quotient/remainder valid.
- REQ-011: div_by_zero  output  1  high with done when the latched divisor was 0; held until next accept.

Function
- REQ-012: FSM states IDLE, DIV, DONE; reset state IDLE.
- REQ-013: start SHALL be accepted in IDLE or DONE only; start in DIV SHALL be ignored, with no effect on operands or count.
- REQ-014: On accept with divisor!=0: latch divisor; load 32-bit quotient shift register with dividend; clear 17-bit partial remainder and 5-bit count; clear div_by_zero; go to DIV.
- REQ-015: Each DIV cycle SHALL perform one restoring step: shift {rem,q} left 1; trial = rem - {1'b0,divisor}; if trial >= 0, rem = trial and q[0] = 1; else q[0] = 0; count++.
- REQ-016: On the DIV cycle with count==31 (32nd step), the FSM SHALL go to DONE.
- REQ-017: done SHALL be high exactly in the DONE cycle: 33 clocks after the accepting edge for divisor!=0 (start at edge E0, steps at E1..E32, done high between E32 and E33).
- REQ-018: On accept with divisor==0: go directly to DONE, with quotient=32'hFFFFFFFF, remainder=dividend[15:0], div_by_zero=1; done high in the cycle after the accepting edge.
- REQ-019: busy SHALL be 1 exactly while in DIV; busy and done never both 1.
- REQ-020: DONE SHALL last one cycle, then go to IDLE unless start is high in DONE, which is accepted per REQ-014/018 (back-to-back operation).
- REQ-021: quotient/remainder SHALL present the final result from DONE onward and hold until the next accept; during DIV their values are don't-care to the bench.
- REQ-022: Arithmetic: quotient*divisor + remainder == dividend and remainder < divisor for all divisor!=0; no overflow is possible (quotient is 32 bits).

Reset
- REQ-023: rst high at a rising edge SHALL force IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, count=0, regardless of state.
- REQ-024: rst mid-DIV SHALL abort the division; no done pulse for the aborted operation.
- REQ-025: rst takes priority over simultaneous start; start is not accepted that cycle.

Verification
- REQ-026: dividend=32'h0000FFFE, divisor=16'h0002 -> done at start-edge+33, quotient=32'h00007FFF, remainder=0, div_by_zero=0.
- REQ-027: dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=32'h0000FFFF, remainder=0; dividend=32'hAB213305, divisor=16'hFF00 -> quotient=32'h0000ABCD, remainder=16'h0005.
- REQ-028: dividend=32'hFFFFFFFF, divisor=16'h0001 -> quotient=32'hFFFFFFFF, remainder=0.
- REQ-029: divisor=0, dividend=32'h12345678 -> done one cycle after accept, quotient=32'hFFFFFFFF, remainder=16'h5678, div_by_zero=1, busy never high.
- REQ-030: start pulsed with new operands at cycle 10 of a busy operation -> ignored; first result unchanged. Then start held high in DONE -> new operation accepted with no IDLE cycle.
- REQ-031: rst asserted at step 15 of 32 -> next cycle all outputs 0, state IDLE, no done; a subsequent start produces a correct result.
- REQ-032: Randomised run of 1000 operand pairs checked against REQ-022 and against the team multiplier: (a*b)/a == b, remainder 0, for a!=0.
